qos_age_promoter: RTL

- Upstream feeder for the 32-requester QoS round-robin arbiter.
- Passes request lines through unchanged and adds an age boost to each requester's base QoS, so that long-waiting requesters rise in priority.
- Clears a requester's boost when the arbiter grants it or when it withdraws its request.
- The arbiter's grant and grant_valid outputs feed back into this block.

---
 rtl/qos_arb_pkg.sv | 19 +
 rtl/qos_age_cell.sv | 63 ++++++
 rtl/qos_age_promoter.sv | 83 ++++++++
 3 files changed

// File: rtl/qos_arb_pkg.sv
// Constants and the saturating QoS adder shared by the age promoter and the QoS arbiter.
package qos_arb_pkg;

    localparam int N_REQ   = 32;
    localparam int QOS_W   = 4;
    localparam int QOS_MAX = (1 << QOS_W) - 1;

    // The sum carries one extra bit; since QOS_MAX is all ones, any carry means saturate.
    function automatic logic [QOS_W-1:0] qos_sat_add(input logic [QOS_W-1:0] qos,
                                                     input logic [QOS_W-1:0] boost);
        logic [QOS_W:0] sum;
        sum = {1'b0, qos} + {1'b0, boost};
        if (sum[QOS_W]) begin
            return QOS_W'(QOS_MAX);
        end
        return sum[QOS_W-1:0];
    endfunction

endpackage

// File: rtl/qos_age_cell.sv
// Per-requester aging state: wait counter, saturating boost level and the promoted QoS slice.
// With QOS_AGE_STARVE_FLAG_EN defined it also reports when the boost is, or is about to become, saturated.
module qos_age_cell
    import qos_arb_pkg::*;
#(
    parameter int AGE_STEP  = 16,
    parameter int MAX_BOOST = 3,
    parameter int CW        = $clog2(AGE_STEP),
    parameter int BW        = $clog2(MAX_BOOST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             served,
    input  logic [QOS_W-1:0] base_qos,
    output logic [QOS_W-1:0] qos_out
`ifdef QOS_AGE_STARVE_FLAG_EN
    ,
    output logic             at_max,
    output logic             reach_max
`endif
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] boost_q, boost_d;

    always_comb begin
        cnt_d   = cnt_q;
        boost_d = boost_q;
        if (served || !req) begin
            cnt_d   = '0;
            boost_d = '0;
        end else if (boost_q < BW'(MAX_BOOST)) begin
            if (cnt_q == CW'(AGE_STEP - 1)) begin
                cnt_d   = '0;
                boost_d = boost_q + BW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Saturated: the counter parks at zero until the requester is cleared.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            boost_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            boost_q <= boost_d;
        end
    end

    assign qos_out = qos_sat_add(base_qos, QOS_W'(boost_q));

`ifdef QOS_AGE_STARVE_FLAG_EN
    assign at_max    = (boost_q == BW'(MAX_BOOST));
    assign reach_max = (boost_d == BW'(MAX_BOOST)) && (boost_q != BW'(MAX_BOOST));
`endif

endmodule

// File: rtl/qos_age_promoter.sv
// Age-based QoS promoter in front of the QoS round-robin arbiter; grant feedback clears the age.
// Optional starvation reporting is enabled with the QOS_AGE_STARVE_FLAG_EN macro.
module qos_age_promoter
    import qos_arb_pkg::*;
#(
    parameter int N         = N_REQ,
    parameter int QW        = QOS_W,
    parameter int AGE_STEP  = 16,
    parameter int MAX_BOOST = 3,
    parameter int CW        = $clog2(AGE_STEP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
    input  logic [N*QW-1:0] base_qos,
    input  logic [N-1:0]    grant,
    input  logic            grant_valid,
    output logic [N-1:0]    req_out,
    output logic [N*QW-1:0] qos_out
`ifdef QOS_AGE_STARVE_FLAG_EN
    ,
    output logic [N-1:0]    starve,
    output logic            starve_any,
    output logic [15:0]     starve_events
`endif
);

    logic [N-1:0] served;

    assign req_out = req_in;
    // Grant bits are only meaningful when qualified; multiple set bits all clear.
    assign served  = grant & {N{grant_valid}};

`ifdef QOS_AGE_STARVE_FLAG_EN
    logic [N-1:0] at_max;
    logic [N-1:0] reach_max;
`endif

    for (genvar i = 0; i < N; i++) begin : g_cell
        qos_age_cell #(
            .AGE_STEP (AGE_STEP),
            .MAX_BOOST(MAX_BOOST),
            .CW       (CW)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .req      (req_in[i]),
            .served   (served[i]),
            .base_qos (base_qos[i*QW +: QW]),
            .qos_out  (qos_out[i*QW +: QW])
`ifdef QOS_AGE_STARVE_FLAG_EN
            ,
            .at_max   (at_max[i]),
            .reach_max(reach_max[i])
`endif
        );
    end

`ifdef QOS_AGE_STARVE_FLAG_EN
    logic [15:0] starve_events_q, starve_events_d;

    // One count per cycle however many requesters saturate together.
    always_comb begin
        starve_events_d = starve_events_q;
        if (|reach_max && starve_events_q != 16'hFFFF) begin
            starve_events_d = starve_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_events_q <= '0;
        end else begin
            starve_events_q <= starve_events_d;
        end
    end

    assign starve        = at_max;
    assign starve_any    = |at_max;
    assign starve_events = starve_events_q;
`endif

endmodule
